// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage-register state encoding and default NOP payload.
// The state values double as the occupancy count.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StFull    = 2'd1,
        StSkidded = 2'd2
    } stage_state_e;

    localparam int unsigned DefaultDataW = 32;
    localparam logic [DefaultDataW-1:0] DefaultNop = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush and bubble counter.
// Empty slots always carry NOP_DATA so downstream sees a harmless payload.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter bit                SKID     = 1'b1,
    parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(DefaultNop),
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_allow_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_allow_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              allow_q;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              accept, drain;

    assign out_valid_o  = (state_q != StEmpty);
    assign out_data_o   = main_q;
    assign occ_o        = state_q;
    assign bubble_cnt_o = bubble_q;

    // With SKID the ready is registered to break the out_allow_i -> in_allow_o timing path.
    assign in_allow_o = SKID ? allow_q : (~out_valid_o | out_allow_i);

    assign accept = in_valid_i & in_allow_o & ~flush_i;
    assign drain  = out_valid_o & out_allow_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
            main_d  = NOP_DATA;
            skid_d  = NOP_DATA;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StFull;
                        main_d  = in_data_i;
                    end
                end
                StFull: begin
                    if (accept && drain) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = StSkidded;
                        skid_d  = in_data_i;
                    end else if (drain) begin
                        state_d = StEmpty;
                        main_d  = NOP_DATA;
                    end
                end
                StSkidded: begin
                    if (drain) begin
                        state_d = StFull;
                        main_d  = skid_q;
                        skid_d  = NOP_DATA;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = NOP_DATA;
                    skid_d  = NOP_DATA;
                end
            endcase
        end
    end

    always_comb begin
        bubble_d = bubble_q;
        if (out_allow_i && !out_valid_o && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q  <= StEmpty;
            main_q   <= NOP_DATA;
            skid_q   <= NOP_DATA;
            allow_q  <= 1'b1;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            allow_q  <= (state_d != StSkidded);
            bubble_q <= bubble_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, queue-based random
// scoreboard for both SKID settings, bubble saturation and asynchronous reset.
module tb_pipe_stage_reg;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        out_allow_i;
    logic        flush_i;

    logic        in_allow1, out_valid1;
    logic [31:0] out_data1;
    logic [1:0]  occ1;
    logic [3:0]  bub1;
    logic        in_allow0, out_valid0;
    logic [31:0] out_data0;
    logic [1:0]  occ0;
    logic [3:0]  bub0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .NOP_DATA(Nop), .CNT_W(4)) u_dut1 (
        .clk_i(clk_i), .rst(rst), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_allow_o(in_allow1), .out_valid_o(out_valid1), .out_data_o(out_data1),
        .out_allow_i(out_allow_i), .flush_i(flush_i), .occ_o(occ1), .bubble_cnt_o(bub1)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .NOP_DATA(Nop), .CNT_W(4)) u_dut0 (
        .clk_i(clk_i), .rst(rst), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_allow_o(in_allow0), .out_valid_o(out_valid0), .out_data_o(out_data0),
        .out_allow_i(out_allow_i), .flush_i(flush_i), .occ_o(occ0), .bubble_cnt_o(bub0)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        oa;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        ea;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [31:0] d, logic oa, logic fl,
                                logic ev, logic [31:0] ed, logic [1:0] eo, logic ea);
        vec_t v;
        v.iv = iv; v.d = d; v.oa = oa; v.fl = fl;
        v.ev = ev; v.ed = ed; v.eo = eo; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst = 1'b1;
        in_valid_i = 1'b0; in_data_i = 32'h0; out_allow_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid1"}, 32'(out_valid1), 32'd0);
        check({tag, "_data1"},  out_data1,       Nop);
        check({tag, "_occ1"},   32'(occ1),       32'd0);
        check({tag, "_allow1"}, 32'(in_allow1),  32'd1);
        check({tag, "_bub1"},   32'(bub1),       32'd0);
        check({tag, "_valid0"}, 32'(out_valid0), 32'd0);
        check({tag, "_data0"},  out_data0,       Nop);
        check({tag, "_allow0"}, 32'(in_allow0),  32'd1);
    endtask

    // Reference model: each stage is just a FIFO of held payloads.
    logic [31:0] q1[$];
    logic [31:0] q0[$];
    logic        m_allow1;
    int          mb1, mb0;

    vec_t tbl[15];

    initial begin
        int accepted;
        int cycles;
        logic acc1, drn1, acc0, drn0, a0;

        rst = 1'b1;
        in_valid_i = 1'b0; in_data_i = 32'h0; out_allow_i = 1'b0; flush_i = 1'b0;
        #2;
        check_reset_outputs("reset");

        tbl[0]  = mk(1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 32'h1, 2'd1, 1'b1);
        tbl[1]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, Nop,   2'd0, 1'b1);
        tbl[2]  = mk(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1);
        tbl[3]  = mk(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0);
        tbl[4]  = mk(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0);
        tbl[5]  = mk(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0);
        tbl[6]  = mk(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0);
        tbl[7]  = mk(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 2'd1, 1'b1);
        tbl[8]  = mk(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hC, 2'd1, 1'b1);
        tbl[9]  = mk(1'b0, 32'hC, 1'b1, 1'b0, 1'b0, Nop,   2'd0, 1'b1);
        tbl[10] = mk(1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 32'hD, 2'd1, 1'b1);
        tbl[11] = mk(1'b1, 32'hE, 1'b0, 1'b0, 1'b1, 32'hD, 2'd2, 1'b0);
        tbl[12] = mk(1'b1, 32'hF, 1'b1, 1'b1, 1'b0, Nop,   2'd0, 1'b1);
        tbl[13] = mk(1'b1, 32'h9, 1'b1, 1'b1, 1'b0, Nop,   2'd0, 1'b1);
        tbl[14] = mk(1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 32'h5, 2'd1, 1'b1);

        @(negedge clk_i);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid_i = tbl[i].iv; in_data_i = tbl[i].d;
            out_allow_i = tbl[i].oa; flush_i = tbl[i].fl;
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(out_valid1), 32'(tbl[i].ev));
            check($sformatf("vec%0d_data", i),  out_data1,       tbl[i].ed);
            check($sformatf("vec%0d_occ", i),   32'(occ1),       32'(tbl[i].eo));
            check($sformatf("vec%0d_allow", i), 32'(in_allow1),  32'(tbl[i].ea));
            @(negedge clk_i);
        end

        // Random stream against the FIFO model, both SKID variants in lockstep.
        do_reset();
        q1.delete(); q0.delete();
        m_allow1 = 1'b1; mb1 = 0; mb0 = 0;
        accepted = 0; cycles = 0;
        while (accepted < 100 && cycles < 3000) begin
            in_valid_i  = ($urandom_range(0, 9) < 7);
            in_data_i   = $urandom;
            out_allow_i = $urandom_range(0, 1) == 1;
            flush_i     = ($urandom_range(0, 49) == 0);
            #1;
            a0 = (q0.size() == 0) || out_allow_i;
            check("rand_allow0", 32'(in_allow0), 32'(a0));
            out_allow_i = ~out_allow_i;
            #1;
            check("rand_allow1_nocomb", 32'(in_allow1), 32'(m_allow1));
            out_allow_i = ~out_allow_i;
            #1;
            acc1 = in_valid_i && m_allow1 && !flush_i;
            drn1 = (q1.size() > 0) && out_allow_i;
            acc0 = in_valid_i && a0 && !flush_i;
            drn0 = (q0.size() > 0) && out_allow_i;
            @(posedge clk_i);
            if (out_allow_i && q1.size() == 0 && mb1 < 15) mb1++;
            if (out_allow_i && q0.size() == 0 && mb0 < 15) mb0++;
            if (flush_i) q1.delete();
            else begin
                if (drn1) void'(q1.pop_front());
                if (acc1) q1.push_back(in_data_i);
            end
            if (flush_i) q0.delete();
            else begin
                if (drn0) void'(q0.pop_front());
                if (acc0) q0.push_back(in_data_i);
            end
            m_allow1 = (q1.size() < 2);
            if (acc1) accepted++;
            cycles++;
            #1;
            check("rand_valid1", 32'(out_valid1), 32'(q1.size() > 0));
            check("rand_data1",  out_data1,       (q1.size() > 0) ? q1[0] : Nop);
            check("rand_occ1",   32'(occ1),       32'(q1.size()));
            check("rand_allow1", 32'(in_allow1),  32'(m_allow1));
            check("rand_bub1",   32'(bub1),       32'(mb1));
            check("rand_valid0", 32'(out_valid0), 32'(q0.size() > 0));
            check("rand_data0",  out_data0,       (q0.size() > 0) ? q0[0] : Nop);
            check("rand_occ0",   32'(occ0),       32'(q0.size()));
            check("rand_bub0",   32'(bub0),       32'(mb0));
            @(negedge clk_i);
        end
        check("rand_accepted_100", 32'(accepted >= 100), 32'd1);

        // Bubble counter saturation at 2^4-1.
        do_reset();
        out_allow_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("bubble%0d_1", i), 32'(bub1), 32'((i + 1 > 15) ? 15 : i + 1));
            check($sformatf("bubble%0d_0", i), 32'(bub0), 32'((i + 1 > 15) ? 15 : i + 1));
        end

        // Asynchronous reset with both entries held.
        do_reset();
        out_allow_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b1; in_data_i = 32'hA; out_allow_i = 1'b0;
        @(negedge clk_i);
        in_data_i = 32'hB;
        @(posedge clk_i);
        #1;
        check("arst_pre_occ1", 32'(occ1), 32'd2);
        check("arst_pre_bub1", 32'(bub1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        @(negedge clk_i);
        rst = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h77; out_allow_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("arst_first_valid", 32'(out_valid1), 32'd1);
        check("arst_first_data",  out_data1,       32'h77);
        check("arst_first_occ",   32'(occ1),       32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 32, payload width in bits (1..512).
REQ-002 Parameter SKID, 1, 1 = two-entry skid buffer with registered in_allow_o; 0 = single register with combinational in_allow_o.
REQ-003 Parameter NOP_DATA, DATA_W'(0), payload driven on out_data_o whenever out_valid_o=0.
REQ-004 Parameter CNT_W, 16, width of the saturating bubble counter.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid_i  in  1  upstream stage holds a valid payload.
REQ-008 in_data_i  in  DATA_W  upstream payload.
REQ-009 in_allow_o  out  1  stage can accept a payload this cycle.
REQ-010 out_valid_o  out  1  out_data_o is a valid payload.
REQ-011 out_data_o  out  DATA_W  registered payload to downstream.
REQ-012 out_allow_i  in  1  downstream accepts out_data_o this cycle.
REQ-013 flush_i  in  1  synchronous kill of all held and incoming payloads.
REQ-014 occ_o  out  2  number of payloads held (0..2; max 1 when SKID=0).
REQ-015 bubble_cnt_o  out  CNT_W  cycles with out_allow_i=1 and out_valid_o=0, saturating.

Function
REQ-016 Accept = in_valid_i & in_allow_o & ~flush_i; Drain = out_valid_o & out_allow_i.
REQ-017 Latency in_data_i -> out_data_o SHALL be exactly 1 cycle when the stage is empty.
REQ-018 SKID=1 states: EMPTY (occ 0), FULL (main valid, occ 1), SKIDDED (main+skid valid, occ 2).
REQ-019 EMPTY: Accept -> FULL, main<=in_data_i; otherwise stay.
REQ-020 FULL: Accept&Drain -> FULL, main<=in_data_i; Accept&~Drain -> SKIDDED, skid<=in_data_i; ~Accept&Drain -> EMPTY; neither -> hold.
REQ-021 SKIDDED: Drain -> FULL, main<=skid; otherwise hold; no Accept possible.
REQ-022 SKID=1: in_allow_o SHALL be ~(state==SKIDDED), a pure register output with no combinational path from out_allow_i.
REQ-023 SKID=0: in_allow_o = ~out_valid_o | out_allow_i; FULL with Accept&Drain reloads main; SKIDDED unreachable.
REQ-024 Payload order SHALL be preserved; no payload duplicated or dropped except by flush_i.
REQ-025 flush_i=1 SHALL, at the next edge, force EMPTY, out_data_o<=NOP_DATA, skid<=NOP_DATA, regardless of in_valid_i/out_allow_i; flush overrides simultaneous Accept and Drain.
REQ-026 Whenever state becomes EMPTY, out_data_o SHALL equal NOP_DATA in that same cycle.
REQ-027 bubble_cnt_o SHALL increment by 1 per cycle with out_allow_i=1 & out_valid_o=0, holding at 2^CNT_W-1; flush_i does not clear it.
REQ-028 in_data_i SHALL be ignored (not sampled) when Accept=0.

Reset
REQ-029 rst=1 SHALL asynchronously force: state EMPTY, out_valid_o=0, out_data_o=NOP_DATA, skid=NOP_DATA, occ_o=0, bubble_cnt_o=0, in_allow_o=1.
REQ-030 Reset asserted mid-transfer SHALL discard both entries; first Accept is possible on the first rising edge after rst deasserts.

Structure
REQ-031 State encoding localparams and the default NOP payload constant SHALL reside in the shared pipeline package/define file.
REQ-032 Implementation SHALL be one module; no sub-module; the execute/memory stage registers SHALL be instantiable as pipe_stage_reg with concatenated payload.

Verification
REQ-033 DATA_W=32, NOP_DATA=32'h0000_0013, SKID=1: in A=32'h1 valid, out_allow_i=1 -> next cycle out_valid_o=1, out_data_o=32'h1, occ_o=1.
REQ-034 out_allow_i=0, push 32'hA then 32'hB -> occ_o=2, in_allow_o=0; push 32'hC held 3 cycles; release out_allow_i -> outputs A,B,C in order, none lost.
REQ-035 occ_o=2, flush_i=1 with in_valid_i=1, out_allow_i=1 -> next cycle occ_o=0, out_valid_o=0, out_data_o=32'h13, in_allow_o=1.
REQ-036 Stream 100 payloads with random out_allow_i (50%) and in_valid_i (70%) -> scoreboard matches exactly; SKID=1 in_allow_o never combinationally follows out_allow_i.
REQ-037 CNT_W=4, out_allow_i=1, in_valid_i=0 for 20 cycles -> bubble_cnt_o=15 and holds.
REQ-038 Assert rst asynchronously between edges with occ_o=2 -> outputs at reset values immediately, before next clk_i edge.
